// File: rtl/dut_seq_pkg.sv
// Shared types and default widths for the vector sequencer.
//   seq_state_t : sequencer FSM states
//   res_entry_t : layout of one result FIFO entry {data, mismatch, idx}
package dut_seq_pkg;

  localparam int IN_W_DEF  = 150;
  localparam int OUT_W_DEF = 80;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // The top packs FIFO entries flat in this same field order so the
  // widths can follow the module parameters.
  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic                 mismatch;
    logic [CNT_W_DEF-1:0] idx;
  } res_entry_t;

endpackage

// File: rtl/dut_seq_fifo.sv
// Synchronous FIFO holding captured results.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the FIFO (start of a run)
//   push, wr_data : write one entry
//   pop           : drop the head; ignored while empty
//   rd_valid      : head valid
//   rd_data       : head entry
//   count         : number of stored entries (0..DEPTH)
module dut_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push) - CW'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Upstream credit accounting must keep a full FIFO from being pushed
  // unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    assert (rst || !(push && !pop_ok && count_q == FULL_C));
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dut_vector_sequencer.sv
// Streams stimulus vectors into a combinational dut, compares each result
// against its golden vector and buffers it for the result sink.
//   start/num_vectors              : launch a run of N vectors (IDLE only)
//   vec_valid/vec_ready/vec_data/vec_exp : stimulus + golden handshake
//   dut_in/dut_out                 : registered drive to dut, its response
//   res_valid/res_ready/res_*      : result FIFO head
//   busy/done                      : run status, done pulses once per run
//   err_count/first_err_idx        : mismatch statistics of the run
module dut_vector_sequencer
  import dut_seq_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  input  logic [OUT_W-1:0] vec_exp,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_mismatch,
  output logic [CNT_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int EW = OUT_W + 1 + CNT_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, issued_q, issued_d, idx_q, idx_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, first_err_idx_q, first_err_idx_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic             s1_vld_q, s1_vld_d;

  logic             accept, push, pop, flush, mismatch, fifo_valid;
  logic [CW-1:0]    fifo_count;
  logic [EW-1:0]    wr_entry, rd_entry;

  // Credit: entries already stored plus the one vector waiting in stage 1
  // must leave room, so a stalled sink can never overflow the FIFO.
  assign vec_ready = (state_q == S_RUN) && (issued_q < n_q) &&
                     (({1'b0, fifo_count} + {{CW{1'b0}}, s1_vld_q}) < DEPTH_W);
  assign accept    = vec_ready && vec_valid;

  // Stage 2: dut_out reflects dut_in captured on the previous edge.
  assign push      = s1_vld_q;
  assign mismatch  = (dut_out != exp_q);
  assign wr_entry  = {dut_out, mismatch, idx_q};
  assign pop       = res_ready && fifo_valid;
  assign flush     = (state_q == S_IDLE) && start && (num_vectors != '0);

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    issued_d        = issued_q;
    idx_d           = idx_q;
    dut_in_d        = dut_in_q;
    exp_d           = exp_q;
    s1_vld_d        = accept;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;

    if (accept) begin
      dut_in_d = vec_data;
      exp_d    = vec_exp;
      idx_d    = issued_q;
      issued_d = issued_q + CNT_W'(1);
    end

    if (push && mismatch) begin
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      if (first_err_idx_q == '1) first_err_idx_d = idx_q;
    end

    case (state_q)
      S_IDLE: if (start) begin
        if (num_vectors != '0) begin
          state_d         = S_RUN;
          n_d             = num_vectors;
          issued_d        = '0;
          err_count_d     = '0;
          first_err_idx_d = '1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN:   if (issued_q == n_q) state_d = S_DRAIN;
      // Leave as soon as the final pop is happening, so done follows it
      // by one cycle.
      S_DRAIN: if (!s1_vld_q && (fifo_count == '0 ||
                                 (fifo_count == CW'(1) && pop)))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      n_q             <= '0;
      issued_q        <= '0;
      idx_q           <= '0;
      dut_in_q        <= '0;
      exp_q           <= '0;
      s1_vld_q        <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '1;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      issued_q        <= issued_d;
      idx_q           <= idx_d;
      dut_in_q        <= dut_in_d;
      exp_q           <= exp_d;
      s1_vld_q        <= s1_vld_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  dut_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .wr_data  (wr_entry),
    .pop      (pop),
    .rd_valid (fifo_valid),
    .rd_data  (rd_entry),
    .count    (fifo_count)
  );

  // Head fields read as zero while the FIFO is empty.
  assign res_valid     = fifo_valid;
  assign res_data      = fifo_valid ? rd_entry[EW-1 -: OUT_W] : '0;
  assign res_mismatch  = fifo_valid ? rd_entry[CNT_W]         : 1'b0;
  assign res_idx       = fifo_valid ? rd_entry[CNT_W-1:0]     : '0;
  assign dut_in        = dut_in_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Self-checking bench: a behavioural dut stands in for the real one, and a
// queue-based model of the run predicts handshakes, results and status.
module tb_dut_vector_sequencer;
  localparam int IN_W = 150, OUT_W = 80, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, vec_valid = 1'b0, res_ready = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [IN_W-1:0]  vec_data = '0;
  logic [OUT_W-1:0] vec_exp = '0;
  logic vec_ready, res_valid, res_mismatch, busy, done;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out, res_data;
  logic [CNT_W-1:0] res_idx, err_count, first_err_idx;

  always #5 clk = ~clk;

  // Stand-in dut: a mix of input bits, with out[4] tied to 0.
  function automatic logic [OUT_W-1:0] dut_f(logic [IN_W-1:0] x);
    logic [OUT_W-1:0] y;
    y = x[79:0] ^ x[149:70] ^ {x[9:0], x[149:80]};
    y[4] = 1'b0;
    return y;
  endfunction

  assign dut_out = dut_f(dut_in);

  dut_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_exp(vec_exp),
    .dut_in(dut_in), .dut_out(dut_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_mismatch(res_mismatch), .res_idx(res_idx),
    .busy(busy), .done(done), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  int errs = 0, checks = 0;

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  typedef struct { logic [OUT_W-1:0] d; logic mm; int idx; int cyc; } ent_t;
  ent_t q[$];
  int   m_acc, m_pop, m_n, cyc;
  logic m_run, m_busy, m_done_next, seen_done;

  task automatic model_reset();
    q.delete();
    m_acc = 0; m_pop = 0; m_n = 0;
    m_run = 1'b0; m_busy = 1'b0; m_done_next = 1'b0; seen_done = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; checks outputs,
  // records the handshakes of the coming rising edge, advances one cycle.
  task automatic cycle();
    logic exp_rdy, exp_rv, acc, pp;
    ent_t e;
    exp_rdy = m_run && (m_acc < m_n) && ((m_acc - m_pop) < DEPTH);
    exp_rv  = (q.size() != 0) && (q[0].cyc + 2 <= cyc);
    chk("vec_ready", vec_ready, exp_rdy);
    chk("res_valid", res_valid, exp_rv);
    chk("done", done, m_done_next);
    chk("busy", busy, m_busy);
    acc = vec_ready && vec_valid;
    pp  = res_valid && res_ready;
    if (pp) begin
      if (q.size() == 0) chk("pop_with_empty_model", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_data", res_data, e.d);
        chk("res_mismatch", res_mismatch, e.mm);
        chk("res_idx", res_idx, e.idx);
        m_pop++;
      end
    end
    if (acc) begin
      e.d = dut_f(vec_data); e.mm = (dut_f(vec_data) != vec_exp);
      e.idx = m_acc; e.cyc = cyc;
      q.push_back(e);
      m_acc++;
    end
    if (m_done_next) begin m_busy = 1'b0; seen_done = 1'b1; end
    m_done_next = pp && (m_pop == m_n);
    cyc++;
    @(negedge clk);
  endtask

  // mode: 0 = always 1, 1 = random, 2 = always 0
  task automatic drive(int vmode, int rmode, logic [15:0] mask);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    vec_data  = r[IN_W-1:0];
    vec_exp   = dut_f(vec_data);
    if (m_acc < 16 && mask[m_acc]) vec_exp[4] = 1'b1;
    vec_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'($urandom % 2) : 1'b0;
    res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom % 2) : 1'b0;
    cycle();
  endtask

  task automatic start_run(int n);
    start = 1'b1; num_vectors = 16'(n); vec_valid = 1'b0; res_ready = 1'b0;
    cycle();
    start = 1'b0;
    m_run = 1'b1; m_busy = 1'b1; m_acc = 0; m_pop = 0; m_n = n;
    m_done_next = (n == 0); seen_done = 1'b0;
  endtask

  typedef struct {
    int n; logic [15:0] mask; int vmode; int rmode; int mid_start;
    int exp_err; logic [15:0] exp_first;
  } scn_t;
  scn_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4,  16'h0000, 0, 0, -1, 0, 16'hFFFF};
    tbl[1] = '{3,  16'h0002, 0, 0, -1, 1, 16'h0001};
    tbl[2] = '{10, 16'h0124, 1, 1, -1, 3, 16'h0002};
    tbl[3] = '{5,  16'h0018, 0, 1,  2, 2, 16'h0003};
    tbl[4] = '{7,  16'h0000, 1, 0, -1, 0, 16'hFFFF};
    tbl[5] = '{0,  16'h0000, 0, 0, -1, 0, 16'hFFFF};

    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_vec_ready", vec_ready, 0);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_mismatch", res_mismatch, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err_idx", first_err_idx, 16'hFFFF);

    for (int s = 0; s < 6; s++) begin
      start_run(tbl[s].n);
      for (int it = 0; it < 400 && !seen_done; it++) begin
        if (it == tbl[s].mid_start) begin start = 1'b1; num_vectors = 16'd2; end
        else start = 1'b0;
        drive(tbl[s].vmode, tbl[s].rmode, tbl[s].mask);
      end
      start = 1'b0;
      chk($sformatf("scn%0d_done_seen", s), seen_done, 1);
      chk($sformatf("scn%0d_results", s), m_pop, tbl[s].n);
      drive(2, 2, 16'h0);
      chk($sformatf("scn%0d_err_count", s), err_count, tbl[s].exp_err);
      chk($sformatf("scn%0d_first_err_idx", s), first_err_idx, tbl[s].exp_first);
    end

    // Back-pressure: with the sink stalled only DEPTH vectors get in.
    start_run(8);
    for (int i = 0; i < 10; i++) drive(0, 2, 16'h0);
    chk("bp_accepts_stalled", m_acc, DEPTH);
    for (int i = 0; i < 100 && !seen_done; i++) drive(0, 0, 16'h0);
    chk("bp_done_seen", seen_done, 1);
    chk("bp_results", m_pop, 8);

    // Reset in the middle of a run with two results buffered.
    start_run(6);
    for (int i = 0; i < 10 && m_acc < 2; i++) drive(0, 2, 16'h0001);
    for (int i = 0; i < 3; i++) drive(2, 2, 16'h0001);
    chk("mid_rst_pre_res_valid", res_valid, 1);
    chk("mid_rst_pre_err_count", err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_first_err_idx", first_err_idx, 16'hFFFF);
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
